// File: rtl/qarctan_iter_pkg.sv
// Shared constants, fixed-point helpers and FSM state type for the iterative quantised arctan.
package qarctan_iter_pkg;

  localparam int BITS  = 10;
  localparam int QUAD1 = 804;   // pi/4 scaled by 2**BITS
  localparam int QUAD3 = 2412;  // 3pi/4 scaled by 2**BITS

  typedef enum logic [1:0] {IDLE, DIV, CALC, OUT} qarc_state_t;

  function automatic logic signed [63:0] quantize_i(input logic signed [63:0] a);
    return a <<< BITS;
  endfunction

  // Truncates toward zero, matching C integer division by 2**BITS.
  function automatic logic signed [63:0] dequantize_i(input logic signed [63:0] a);
    return (a < 0) ? -((-a) >>> BITS) : (a >>> BITS);
  endfunction

endpackage

// File: rtl/qarctan_divider.sv
// Iterative restoring divider with start/done handshake; QARCTAN_RADIX4_EN selects 2 quotient bits/cycle.
module qarctan_divider
  import qarctan_iter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WW     = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WW-1:0]            num,
  input  logic [WW-1:0]            den,
  input  logic                     neg,
  output logic                     done,
  output logic signed [DATA_W-1:0] quo
);

`ifdef QARCTAN_RADIX4_EN
  localparam int RB = 2;
`else
  localparam int RB = 1;
`endif
  localparam int N  = (BITS + RB) / RB;  // ceil((BITS+1)/RB)
  localparam int QW = N * RB;
  localparam int CW = $clog2(N + 1);

  logic [WW-1:0]     rem_q, dsh_q, rem_n, dsh_n;
  logic [QW-1:0]     q_q, q_n;
  logic [CW-1:0]     cnt_q, idx;
  logic              busy_q, neg_q, run;
  logic [DATA_W-1:0] mag;

  // The start cycle iterates on the fresh operands so the divide takes exactly N cycles.
  always_comb begin
    run   = start | busy_q;
    rem_n = start ? num : rem_q;
    dsh_n = start ? (den << (QW - 1)) : dsh_q;
    q_n   = start ? '0 : q_q;
    idx   = start ? '0 : cnt_q;
    for (int i = 0; i < RB; i++) begin
      if (rem_n >= dsh_n) begin
        rem_n = rem_n - dsh_n;
        q_n   = {q_n[QW-2:0], 1'b1};
      end else begin
        q_n   = {q_n[QW-2:0], 1'b0};
      end
      dsh_n = dsh_n >> 1;
    end
    done = run && (idx == CW'(N - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (run) begin
      rem_q  <= rem_n;
      dsh_q  <= dsh_n;
      q_q    <= q_n;
      cnt_q  <= idx + CW'(1);
      busy_q <= !done;
      if (start) neg_q <= neg;
    end
  end

  assign mag = {{(DATA_W-QW){1'b0}}, q_q};
  assign quo = neg_q ? -signed'(mag) : signed'(mag);

endmodule

// File: rtl/qarctan_iter.sv
// Multi-cycle quantised arctan: FIFO pop, iterative divide, angle calc, FIFO push.
// Build option QARCTAN_RADIX4_EN halves divide cycles with bit-identical results.
module qarctan_iter
  import qarctan_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              inA_rd_en,
  input  logic              inA_empty,
  input  logic [DATA_W-1:0] inA_dout,
  output logic              inB_rd_en,
  input  logic              inB_empty,
  input  logic [DATA_W-1:0] inB_dout,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic [DATA_W-1:0] out_din
);

  localparam int WW = 2 * DATA_W;

  qarc_state_t state, state_n;

  logic signed [DATA_W-1:0] x_r, quo, ang;
  logic [DATA_W-1:0]        out_r;
  logic signed [WW-1:0]     abs_y_r, abs_y_in, y_in, x_w, diff, num_s, den_s, q_w, prod, deq, base;
  logic [WW-1:0]            num_mag;
  logic                     y_neg_r, x_pos, num_neg, pop, start_r, div_done;

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    out_wr_en = 1'b0;
    case (state)
      IDLE: begin
        pop = !inA_empty && !inB_empty;
        if (pop) state_n = DIV;
      end
      DIV:  if (div_done) state_n = CALC;
      CALC: state_n = OUT;
      OUT: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          pop       = !inA_empty && !inB_empty;
          state_n   = pop ? DIV : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (reset) pop = 1'b0;
  end

  assign inA_rd_en = pop;
  assign inB_rd_en = pop;

  always_comb begin
    y_in     = WW'(signed'(inA_dout));
    abs_y_in = ((y_in < 0) ? -y_in : y_in) + WW'(1);
    x_w      = WW'(x_r);
    x_pos    = !x_r[DATA_W-1];
    diff     = x_pos ? (x_w - abs_y_r) : (x_w + abs_y_r);
    num_s    = WW'(quantize_i(64'(diff)));
    den_s    = x_pos ? (x_w + abs_y_r) : (abs_y_r - x_w);
    num_neg  = num_s < 0;
    num_mag  = num_neg ? -num_s : num_s;
    q_w      = WW'(quo);
    prod     = q_w * WW'(QUAD1);
    deq      = WW'(dequantize_i(64'(prod)));
    base     = x_pos ? WW'(QUAD1) : WW'(QUAD3);
    ang      = DATA_W'(base - deq);
    if (y_neg_r) ang = -ang;
  end

  qarctan_divider #(.DATA_W(DATA_W), .WW(WW)) u_div (
    .clock (clock),
    .reset (reset),
    .start (start_r),
    .num   (num_mag),
    .den   (den_s),
    .neg   (num_neg),
    .done  (div_done),
    .quo   (quo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      x_r     <= '0;
      abs_y_r <= '0;
      y_neg_r <= 1'b0;
      out_r   <= '0;
      start_r <= 1'b0;
    end else begin
      state   <= state_n;
      start_r <= pop;
      if (pop) begin
        x_r     <= signed'(inB_dout);
        abs_y_r <= abs_y_in;
        y_neg_r <= inA_dout[DATA_W-1];
      end
      if (state == CALC) out_r <= ang;
    end
  end

  assign out_din = out_r;

endmodule

// File: tb/tb_qarctan_iter.sv
// Directed-vector and corner-sequence bench for qarctan_iter, plus random pairs against a C-style model.
module tb_qarctan_iter;

`ifdef QARCTAN_RADIX4_EN
  localparam int N = 6;
`else
  localparam int N = 11;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inA_empty = 1'b1, inB_empty = 1'b1, out_full = 1'b0;
  logic [31:0] inA_dout = '0, inB_dout = '0;
  logic        inA_rd_en, inB_rd_en, out_wr_en;
  logic [31:0] out_din;

  int cyc = 0;
  int ncmp = 0;
  int nerr = 0;

  qarctan_iter #(.DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .inA_rd_en (inA_rd_en),
    .inA_empty (inA_empty),
    .inA_dout  (inA_dout),
    .inB_rd_en (inB_rd_en),
    .inB_empty (inB_empty),
    .inB_dout  (inB_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string nm;
    int    y;
    int    x;
    int    exp;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic longint model(input longint y, input longint x);
    longint ay, r, a;
    ay = ((y < 0) ? -y : y) + 1;
    if (x >= 0) r = ((x - ay) * 1024) / (x + ay);
    else        r = ((x + ay) * 1024) / (ay - x);
    a = ((x >= 0) ? 804 : 2412) - (804 * r) / 1024;
    return (y < 0) ? -a : a;
  endfunction

  function automatic longint sout();
    return longint'(signed'(out_din));
  endfunction

  task automatic drive(input int y, input int x);
    inA_dout  = y;
    inB_dout  = x;
    inA_empty = 1'b0;
    inB_empty = 1'b0;
  endtask

  task automatic wait_pop(output int t);
    t = -1000;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (inA_rd_en) begin
        t = cyc;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_write(output int t, output longint v);
    t = -1000;
    v = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (out_wr_en) begin
        t = cyc;
        v = sout();
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_vec(input string nm, input int y, input int x, input longint exp);
    int tp, tw;
    longint v;
    @(negedge clock);
    drive(y, x);
    wait_pop(tp);
    chk({nm, "_pop_pair"}, longint'(inB_rd_en), 1);
    @(negedge clock);
    inA_empty = 1'b1;
    inB_empty = 1'b1;
    wait_write(tw, v);
    chk(nm, v, exp);
    chk({nm, "_latency"}, tw - tp, N + 2);
  endtask

  initial begin
    vec_t tbl[7];
    int   tp, tw, bad;
    longint v;

    tbl[0] = '{"y0_x1024",     0,     1024,  2};
    tbl[1] = '{"y1024_x0",     1024,  0,     1608};
    tbl[2] = '{"yn1024_x0",    -1024, 0,     -1608};
    tbl[3] = '{"y0_xn1024",    0,     -1024, 3214};
    tbl[4] = '{"y0_x0",        0,     0,     1608};
    tbl[5] = '{"yn1024_xn1024", -1024, -1024, -2412};
    tbl[6] = '{"y3_x5",        3,     5,     716};

    // Reset with both inputs non-empty: nothing may pop.
    drive(1024, 1024);
    repeat (2) @(negedge clock);
    #1;
    chk("reset_rd_en", longint'(inA_rd_en | inB_rd_en), 0);
    chk("reset_wr_en", longint'(out_wr_en), 0);
    chk("reset_out_din", sout(), 0);
    @(negedge clock);
    inA_empty = 1'b1;
    inB_empty = 1'b1;
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i].nm, tbl[i].y, tbl[i].x, tbl[i].exp);

    // Only the y FIFO has data: no pop until x arrives.
    @(negedge clock);
    inA_dout  = 1024;
    inA_empty = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (inA_rd_en || inB_rd_en) bad++;
      @(negedge clock);
    end
    chk("one_side_no_pop", bad, 0);
    inB_dout  = 1024;
    inB_empty = 1'b0;
    #1;
    chk("both_fill_popA", longint'(inA_rd_en), 1);
    chk("both_fill_popB", longint'(inB_rd_en), 1);
    tp = cyc;
    @(negedge clock);
    inA_empty = 1'b1;
    inB_empty = 1'b1;
    wait_write(tw, v);
    chk("both_fill_val", v, 804);
    chk("both_fill_latency", tw - tp, N + 2);

    // Output full for 5 cycles in OUT, next pair already waiting.
    @(negedge clock);
    out_full = 1'b1;
    drive(0, 1024);
    wait_pop(tp);
    bad = 0;
    for (int c = 1; c <= N + 6; c++) begin
      @(negedge clock);
      if (c == 1) drive(1024, 0);
      #1;
      if (inA_rd_en || inB_rd_en || out_wr_en) bad++;
      if (c >= N + 2 && sout() != 2) bad++;
    end
    chk("full_stall_quiet", bad, 0);
    @(negedge clock);
    out_full = 1'b0;
    #1;
    chk("full_release_wr", longint'(out_wr_en), 1);
    chk("full_release_val", sout(), 2);
    chk("full_release_pop", longint'(inA_rd_en & inB_rd_en), 1);
    tp = cyc;
    @(negedge clock);
    inA_empty = 1'b1;
    inB_empty = 1'b1;
    #1;
    chk("full_single_write", longint'(out_wr_en), 0);
    wait_write(tw, v);
    chk("b2b_val", v, 1608);
    chk("b2b_latency", tw - tp, N + 2);

    // Reset pulse while the divider is running drops the pair.
    @(negedge clock);
    drive(0, -1024);
    wait_pop(tp);
    @(negedge clock);
    inA_empty = 1'b1;
    inB_empty = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_reset_out_din", sout(), 0);
    chk("mid_reset_wr_en", longint'(out_wr_en), 0);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (out_wr_en || inA_rd_en) bad++;
      @(negedge clock);
    end
    chk("mid_reset_no_write", bad, 0);

    for (int i = 0; i < 1000; i++) begin
      int ry, rx;
      ry = int'($urandom_range(2097150)) - 1048575;
      rx = int'($urandom_range(2097150)) - 1048575;
      run_vec("rand", ry, rx, model(ry, rx));
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
